// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retirement trace monitor.
package retire_trace_pkg;

  localparam int unsigned TRC_XLEN = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned TYPE_W   = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned ERR_W    = 3;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_RNV  = 1;
  localparam int unsigned ERR_TYPE = 2;

  typedef enum logic [TYPE_W-1:0] {
    ITYPE_R = 6'b000001,
    ITYPE_I = 6'b000010,
    ITYPE_S = 6'b000100,
    ITYPE_B = 6'b001000,
    ITYPE_U = 6'b010000,
    ITYPE_J = 6'b100000
  } instr_type_e;

  typedef struct packed {
    logic [TRC_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
    logic [TYPE_W-1:0]   itype;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [TRC_XLEN-1:0] rd_val;
    logic [TRC_XLEN-1:0] rs1_val;
    logic [TRC_XLEN-1:0] rs2_val;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

  typedef struct packed {
    logic                valid;
    logic [TRC_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
    logic [TYPE_W-1:0]   itype;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
  } shadow_stage_t;

  function automatic logic is_onehot(input logic [TYPE_W-1:0] t);
    return (t != '0) && ((t & (t - TYPE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/retire_trace_unit_fifo.sv
// Synchronous flop-based FIFO; accepts a push while full if a pop happens the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/retire_trace_unit.sv
// Commit-trace monitor: shadows in-flight instructions, records each retirement into a trace FIFO.
module retire_trace_unit
  import retire_trace_pkg::*;
#(
  parameter int unsigned XLEN        = TRC_XLEN,
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MAX_INSTR   = 200
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [XLEN-1:0]    fetch_pc_i,
  input  logic [INSTR_W-1:0] fetch_ins_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [TYPE_W-1:0]  iss_type_i,
  input  logic [REG_W-1:0]   iss_rd_i,
  input  logic [REG_W-1:0]   iss_rs1_i,
  input  logic [REG_W-1:0]   iss_rs2_i,
  input  logic               retire_i,
  input  logic [XLEN-1:0]    rd_val_i,
  input  logic [XLEN-1:0]    rs1_val_i,
  input  logic [XLEN-1:0]    rs2_val_i,
  output logic               trc_valid_o,
  input  logic               trc_ready_i,
  output trace_rec_t         trc_rec_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               done_o,
  output logic [ERR_W-1:0]   err_o
);

  localparam int unsigned WB = N_STAGES - 1;

  shadow_stage_t    stg_q [N_STAGES];
  shadow_stage_t    stg_d [N_STAGES];
  trace_rec_t       rec_c;
  logic             fifo_full, fifo_empty;
  logic             pop_c, accept_c, push_try_c, push_ok_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;

  // Shadow pipeline: stage 0 captures fetch, stage 1 adds ISS decode, older stages shift.
  always_comb begin
    stg_d = stg_q;
    if (!stall_i) begin
      stg_d[0].valid = 1'b1;
      stg_d[0].pc    = TRC_XLEN'(fetch_pc_i);
      stg_d[0].instr = fetch_ins_i;
      stg_d[1]       = stg_q[0];
      stg_d[1].itype = iss_type_i;
      stg_d[1].rd    = iss_rd_i;
      stg_d[1].rs1   = iss_rs1_i;
      stg_d[1].rs2   = iss_rs2_i;
      for (int unsigned k = 2; k < N_STAGES; k++) stg_d[k] = stg_q[k-1];
    end
    // Flushed instructions must not reappear in the first older stage either.
    if (flush_i) begin
      for (int unsigned k = 0; k < FLUSH_DEPTH; k++) stg_d[k].valid = 1'b0;
      if (!stall_i) stg_d[FLUSH_DEPTH].valid = 1'b0;
    end
  end

  always_comb begin
    rec_c.pc      = stg_q[WB].pc;
    rec_c.instr   = stg_q[WB].instr;
    rec_c.itype   = stg_q[WB].itype;
    rec_c.rd      = stg_q[WB].rd;
    rec_c.rs1     = stg_q[WB].rs1;
    rec_c.rs2     = stg_q[WB].rs2;
    rec_c.rd_val  = TRC_XLEN'(rd_val_i);
    rec_c.rs1_val = TRC_XLEN'(rs1_val_i);
    rec_c.rs2_val = TRC_XLEN'(rs2_val_i);
  end

  // Retirement accounting: push acceptance, saturating count, sticky done/error flags.
  always_comb begin
    pop_c      = !fifo_empty && trc_ready_i;
    accept_c   = retire_i && !done_q;
    push_try_c = accept_c && stg_q[WB].valid;
    push_ok_c  = push_try_c && (!fifo_full || pop_c);
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    if (push_ok_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (push_ok_c && (MAX_INSTR != 0) && (cnt_d == CNT_W'(MAX_INSTR))) done_d = 1'b1;
    if (push_try_c && !push_ok_c) err_d[ERR_OVF] = 1'b1;
    if (accept_c && !stg_q[WB].valid) err_d[ERR_RNV] = 1'b1;
    if (push_try_c && !is_onehot(stg_q[WB].itype)) err_d[ERR_TYPE] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_STAGES; k++) stg_q[k] <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= '0;
    end else begin
      stg_q  <= stg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_ok_c),
    .data_i  (rec_c),
    .pop_i   (pop_c),
    .data_o  (trc_rec_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign trc_valid_o = !fifo_empty;
  assign count_o     = cnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Bench for retire_trace_unit: directed phases plus random traffic against a queue-based reference model.
module tb_retire_trace_unit;
  import retire_trace_pkg::*;

  localparam int NS = 4;
  localparam int FD = 2;
  localparam int FDEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fetch_pc, fetch_ins, rd_val, rs1_val, rs2_val;
  logic        stall, flush, retire, trc_ready;
  logic [5:0]  iss_type;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;

  logic        valid_a, valid_b, done_a, done_b;
  trace_rec_t  rec_a, rec_b;
  logic [31:0] count_a, count_b;
  logic [2:0]  err_a, err_b;

  always #5 clk = ~clk;

  retire_trace_unit dut_a (
    .clk(clk), .reset_n(reset_n), .fetch_pc_i(fetch_pc), .fetch_ins_i(fetch_ins),
    .stall_i(stall), .flush_i(flush), .iss_type_i(iss_type), .iss_rd_i(iss_rd),
    .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .retire_i(retire), .rd_val_i(rd_val),
    .rs1_val_i(rs1_val), .rs2_val_i(rs2_val), .trc_valid_o(valid_a), .trc_ready_i(trc_ready),
    .trc_rec_o(rec_a), .count_o(count_a), .done_o(done_a), .err_o(err_a));

  retire_trace_unit #(.MAX_INSTR(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .fetch_pc_i(fetch_pc), .fetch_ins_i(fetch_ins),
    .stall_i(stall), .flush_i(flush), .iss_type_i(iss_type), .iss_rd_i(iss_rd),
    .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .retire_i(retire), .rd_val_i(rd_val),
    .rs1_val_i(rs1_val), .rs2_val_i(rs2_val), .trc_valid_o(valid_b), .trc_ready_i(trc_ready),
    .trc_rec_o(rec_b), .count_o(count_b), .done_o(done_b), .err_o(err_b));

  // Reference model: in-flight instructions tagged with their stage, plus a record list per DUT.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [5:0]  typ;
    logic [4:0]  rd, rs1, rs2;
    int          stage;
  } ent_t;

  ent_t        pl[$];
  trace_rec_t  mfifo [2][FDEPTH];
  int          mhead [2];
  int          msize [2];
  logic [31:0] mcnt [2];
  bit          mdone [2];
  logic [2:0]  merr [2];
  int unsigned maxv [2] = '{200, 4};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_next;
  bit          force_type = 1'b0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pl.delete();
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0;
      msize[i] = 0;
      mcnt[i]  = '0;
      mdone[i] = 1'b0;
      merr[i]  = '0;
    end
  endtask

  function automatic int wb_index();
    int r = -1;
    foreach (pl[j]) if (pl[j].stage == NS-1) r = j;
    return r;
  endfunction

  task automatic model_step();
    int         wbi;
    bit         popq, pushq;
    trace_rec_t r;
    wbi = wb_index();
    r = '0;
    if (wbi >= 0) begin
      r.pc = pl[wbi].pc; r.instr = pl[wbi].ins; r.itype = pl[wbi].typ;
      r.rd = pl[wbi].rd; r.rs1 = pl[wbi].rs1; r.rs2 = pl[wbi].rs2;
    end
    r.rd_val = rd_val; r.rs1_val = rs1_val; r.rs2_val = rs2_val;
    for (int i = 0; i < 2; i++) begin
      popq  = (msize[i] > 0) && trc_ready;
      pushq = 1'b0;
      if (!mdone[i] && retire) begin
        if (wbi < 0) merr[i][1] = 1'b1;
        else begin
          if ($countones(pl[wbi].typ) != 1) merr[i][2] = 1'b1;
          if (msize[i] == FDEPTH && !popq) merr[i][0] = 1'b1;
          else pushq = 1'b1;
        end
      end
      if (popq) begin
        mhead[i] = (mhead[i] + 1) % FDEPTH;
        msize[i]--;
      end
      if (pushq) begin
        mfifo[i][(mhead[i] + msize[i]) % FDEPTH] = r;
        msize[i]++;
        if (mcnt[i] != 32'hFFFF_FFFF) mcnt[i] = mcnt[i] + 1;
        if (maxv[i] != 0 && mcnt[i] == maxv[i]) mdone[i] = 1'b1;
      end
    end
    if (flush)
      for (int j = pl.size() - 1; j >= 0; j--) if (pl[j].stage < FD) pl.delete(j);
    if (!stall) begin
      foreach (pl[j]) begin
        if (pl[j].stage == 0) begin
          pl[j].typ = iss_type; pl[j].rd = iss_rd; pl[j].rs1 = iss_rs1; pl[j].rs2 = iss_rs2;
        end
        pl[j].stage = pl[j].stage + 1;
      end
      for (int j = pl.size() - 1; j >= 0; j--) if (pl[j].stage >= NS) pl.delete(j);
      if (!flush) pl.push_back('{fetch_pc, fetch_ins, 6'd0, 5'd0, 5'd0, 5'd0, 0});
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string nm = (i == 0) ? "a" : "b";
      chk({nm, ".valid"}, (i == 0) ? valid_a : valid_b, msize[i] > 0);
      if (msize[i] > 0) chk({nm, ".rec"}, (i == 0) ? rec_a : rec_b, mfifo[i][mhead[i]]);
      chk({nm, ".count"}, (i == 0) ? count_a : count_b, mcnt[i]);
      chk({nm, ".done"}, (i == 0) ? done_a : done_b, mdone[i]);
      chk({nm, ".err"}, (i == 0) ? err_a : err_b, merr[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a_valid"}, valid_a, 0);
    chk({tag, ".a_count"}, count_a, 0);
    chk({tag, ".a_done"}, done_a, 0);
    chk({tag, ".a_err"}, err_a, 0);
    chk({tag, ".b_valid"}, valid_b, 0);
    chk({tag, ".b_count"}, count_b, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    pc_next = 32'h2000;
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode: 0 retire on valid WB when not stalled, 1 always retire, 2 random, 3 never
  task automatic run(input int n, input int stall_pct, input int flush_pct,
                     input int ready_pct, input int mode);
    bit wbv;
    for (int c = 0; c < n; c++) begin
      stall     = int'($urandom_range(0, 99)) < stall_pct;
      flush     = int'($urandom_range(0, 99)) < flush_pct;
      trc_ready = int'($urandom_range(0, 99)) < ready_pct;
      fetch_pc  = pc_next;
      if (!stall) pc_next = pc_next + 32'd4;
      fetch_ins = $urandom;
      iss_type  = force_type ? 6'b000011 : 6'(1 << $urandom_range(0, 5));
      iss_rd    = 5'($urandom);
      iss_rs1   = 5'($urandom);
      iss_rs2   = 5'($urandom);
      rd_val    = $urandom;
      rs1_val   = $urandom;
      rs2_val   = $urandom;
      wbv       = wb_index() >= 0;
      case (mode)
        0:       retire = wbv && !stall;
        1:       retire = 1'b1;
        2:       retire = wbv ? (int'($urandom_range(0, 99)) < 80) : (int'($urandom_range(0, 99)) < 5);
        default: retire = 1'b0;
      endcase
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    {stall, flush, retire, trc_ready} = '0;
    {fetch_pc, fetch_ins, rd_val, rs1_val, rs2_val} = '0;
    {iss_type, iss_rd, iss_rs1, iss_rs2} = '0;
    @(negedge clk);
    do_reset();

    // Five unstalled retirements; the limited instance stops at four.
    run(9, 0, 0, 100, 0);
    chk("a.count5", count_a, 5);
    chk("a.err5", err_a, 0);
    chk("b.count4", count_b, 4);
    chk("b.done4", done_b, 1);

    // Three-cycle stall mid-stream.
    run(3, 0, 0, 100, 0);
    run(3, 100, 0, 100, 0);
    run(6, 0, 0, 100, 0);
    chk("a.err_stall", err_a, 0);

    // Flush with 0x200C/0x2008 in ISS/EX, retire_i held high through the bubbles.
    do_reset();
    run(4, 0, 0, 100, 0);
    run(1, 0, 100, 100, 1);
    run(4, 0, 0, 100, 1);
    chk("a.count_flush", count_a, 2);
    chk("a.err_rnv", err_a, 3'b010);

    // Overflow with a blocked consumer, then drain.
    do_reset();
    run(21, 0, 0, 0, 0);
    chk("a.count_ovf", count_a, 16);
    chk("a.err_ovf", err_a, 3'b001);
    chk("a.valid_ovf", valid_a, 1);
    run(20, 0, 0, 100, 3);
    chk("a.drained", valid_a, 0);

    // Non-one-hot type on a retired instruction.
    do_reset();
    run(2, 0, 0, 100, 0);
    force_type = 1'b1;
    run(1, 0, 0, 100, 0);
    force_type = 1'b0;
    run(6, 0, 0, 100, 0);
    chk("a.err_type", err_a, 3'b100);

    // Random traffic, an asynchronous reset mid-stream, more random traffic.
    do_reset();
    run(250, 20, 5, 60, 2);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    pc_next = 32'h2000;
    @(negedge clk);
    reset_n = 1'b1;
    run(200, 15, 5, 50, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
